// File: rtl/uart_deserialize.sv
// uart_deserialize: oversampling UART receiver with level-held valid/ack byte output.
// Parity stage is present only when UART_PARITY_EN is defined (11-bit frame), else 10-bit frame.
module uart_deserialize #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_stream,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [W-1:0] FULL = W'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK
`ifdef UART_PARITY_EN
    , PARITY
`endif
  } state_t;
  state_t state;
  logic [1:0] sync, rdy;
  logic [W-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  logic arm, commit, stop_ok;
`ifdef UART_PARITY_EN
  logic perr;
`endif
  logic s;
  assign s = sync[1];
  assign busy = state != IDLE;
  // arm stays low after reset until the settled line is seen high, so a frame cut by reset is not resynchronized on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sync <= 2'b11;
      rdy <= 2'b00;
      arm <= 1'b0;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      commit <= 1'b0;
      stop_ok <= 1'b1;
`ifdef UART_PARITY_EN
      perr <= 1'b0;
`endif
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sync <= {sync[0], uart_stream};
      rdy <= {rdy[0], 1'b1};
      arm <= arm | (rdy[1] & s);
      cnt <= cnt + 1'b1;
      commit <= 1'b0;
      case (state)
        IDLE: if (arm && !s) begin
          cnt <= '0;
          state <= START;
        end
        START: if (cnt == HALF) begin
          cnt <= '0;
          idx <= '0;
          state <= s ? IDLE : DATA;
        end
        DATA: if (cnt == FULL) begin
          cnt <= '0;
          sh <= {s, sh[7:1]};
          idx <= idx + 1'b1;
`ifdef UART_PARITY_EN
          if (idx == 3'd7) state <= PARITY;
`else
          if (idx == 3'd7) state <= STOP;
`endif
        end
`ifdef UART_PARITY_EN
        PARITY: if (cnt == FULL) begin
          cnt <= '0;
          perr <= ^{sh, s};
          state <= STOP;
        end
`endif
        STOP: if (cnt == FULL) begin
          cnt <= '0;
          stop_ok <= s;
          commit <= 1'b1;
          state <= s ? IDLE : BREAK;
        end
        BREAK: if (s) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit) begin
        rx_data <= sh;
        frame_err <= !stop_ok;
`ifdef UART_PARITY_EN
        parity_err <= perr;
`else
        parity_err <= 1'b0;
`endif
        rx_valid <= 1'b1;
        overrun <= (rx_valid && !rx_ack) ? 1'b1 : overrun & !rx_ack;
      end else if (rx_valid && rx_ack) begin
        rx_valid <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_deserialize.sv
// tb_uart_deserialize: directed and randomized frames checked against a frame-level model.
module tb_uart_deserialize;
  localparam int CPB = 16;
`ifdef UART_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, uart_stream = 1'b1, rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, parity_err, overrun, busy;
  int tests = 0, fails = 0, pend = 0;

  uart_deserialize #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .uart_stream(uart_stream), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par = 0, input int stop_low = 0);
    logic q[$];
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (PAR) q.push_back(^d ^ bad_par);
    for (int i = 0; i < stop_low; i++) q.push_back(1'b0);
    q.push_back(1'b1);
    foreach (q[i]) begin
      uart_stream = q[i];
      repeat (CPB) @(negedge clk);
    end
    pend++;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] d, input bit fe, input bit bad_par);
    int n = 0;
    while (!rx_valid && n < 4 * CPB) begin
      @(negedge clk);
      n++;
    end
    check({tag, " valid"}, rx_valid, 1);
    check({tag, " data"}, rx_data, d);
    check({tag, " frame_err"}, frame_err, fe);
    check({tag, " parity_err"}, parity_err, PAR & bad_par);
    check({tag, " overrun"}, overrun, pend > 1);
  endtask

  task automatic ack(input string tag);
    @(negedge clk) rx_ack = 1'b1;
    @(negedge clk) rx_ack = 1'b0;
    pend = 0;
    check({tag, " ack valid"}, rx_valid, 0);
    check({tag, " ack overrun"}, overrun, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " data"}, rx_data, 8'h00);
    check({tag, " valid"}, rx_valid, 0);
    check({tag, " frame_err"}, frame_err, 0);
    check({tag, " parity_err"}, parity_err, 0);
    check({tag, " overrun"}, overrun, 0);
    check({tag, " busy"}, busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    send_frame(8'hA5);
    expect_byte("a5", 8'hA5, 0, 0);
    repeat (20) @(negedge clk);
    check("a5 hold", rx_valid, 1);
    ack("a5");

    @(negedge clk) uart_stream = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch busy", busy, 1);
    @(negedge clk) uart_stream = 1'b1;
    repeat (CPB) @(negedge clk);
    check("glitch idle", busy, 0);
    check("glitch valid", rx_valid, 0);
    check("glitch flags", {frame_err, parity_err, overrun}, 3'b000);

    send_frame(8'h3C, 1);
    expect_byte("3c", 8'h3C, 0, 1);
    ack("3c");

    send_frame(8'h81, 0, 3);
    expect_byte("81", 8'h81, 1, 0);
    ack("81");
    repeat (CPB) @(negedge clk);
    check("brk recovered", busy, 0);
    send_frame(8'h42);
    expect_byte("42", 8'h42, 0, 0);
    ack("42");

    send_frame(8'h11);
    send_frame(8'h22);
    expect_byte("b2b", 8'h22, 0, 0);
    ack("b2b");

    uart_stream = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) repeat (CPB) @(negedge clk) uart_stream = 1'b1;
    uart_stream = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_vals("midrst");
    repeat (3 * CPB + CPB / 2) @(negedge clk);
    uart_stream = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("midrst no byte", rx_valid, 0);
    check("midrst idle", busy, 0);
    send_frame(8'h5A);
    expect_byte("5a", 8'h5A, 0, 0);
    ack("5a");

    for (int k = 0; k < 16; k++) begin
      logic [7:0] d;
      bit bp;
      d = 8'($urandom);
      bp = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2) * CPB) @(negedge clk);
      send_frame(d, bp);
      expect_byte("rnd", d, 0, bp);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      ack("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
